// File: rtl/uart_io_pkg.sv
// Shared constants for the memory-mapped UART: register map, STATUS bit layout,
// FSM encodings and the divisor clamp helper.
package uart_io_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_BAUD    = 2'd3;

  localparam int ST_TX_BUSY      = 0;
  localparam int ST_RX_VALID     = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_RX_FRAME_ERR = 3;
  localparam int ST_TX_DROP      = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable 16-bit down-counter; expire_o pulses for one cycle so that the owner
// acts exactly load_val_i clocks after the load edge.
module uart_bit_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        expire_o
);

  logic [15:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == 16'd1);

endmodule

// File: rtl/uart_io_controller.sv
// 8N1 UART device for the LogicaIO slot: DATA/STATUS/CONTROL/BAUD registers,
// single-byte TX and RX holding registers, 2-flop rx synchroniser.
module uart_io_controller
  import uart_io_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic        cs,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        rx,
  output logic        tx
);

  logic [15:0] baud_q, baud_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic        tx_q, tx_d, tx_drop_q, tx_drop_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_div_q, tx_div_d, tx_tmr_val;
  logic        tx_tmr_load, tx_expire;

  logic        rx_meta_q, rx_s_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [15:0] rx_div_q, rx_div_d, rx_tmr_val;
  logic        rx_tmr_load, rx_expire;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_ferr_q, rx_ferr_d;
  logic        rx_byte_ok, rx_frame_bad, rx_valid_eff;

  logic wr_data, wr_ctrl, wr_baud, clr_valid, clr_err;
  logic [15:0] status;

  assign wr_data   = cs && we && (reg_sel == REG_DATA);
  assign wr_ctrl   = cs && we && (reg_sel == REG_CONTROL);
  assign wr_baud   = cs && we && (reg_sel == REG_BAUD);
  assign clr_valid = wr_ctrl && in[0];
  assign clr_err   = wr_ctrl && in[1];
  assign baud_d    = wr_baud ? in : baud_q;

  uart_bit_timer u_tx_timer (.clk(clk), .reset(reset), .load_i(tx_tmr_load),
                             .load_val_i(tx_tmr_val), .expire_o(tx_expire));
  uart_bit_timer u_rx_timer (.clk(clk), .reset(reset), .load_i(rx_tmr_load),
                             .load_val_i(rx_tmr_val), .expire_o(rx_expire));

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_d        = tx_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_div_d    = tx_div_q;
    tx_drop_d   = tx_drop_q && !clr_err;
    tx_tmr_load = 1'b0;
    tx_tmr_val  = tx_div_q;
    unique case (tx_state_q)
      TX_IDLE: if (wr_data) begin
        tx_state_d  = TX_START;
        tx_d        = 1'b0;
        tx_shift_d  = in[7:0];
        tx_bit_d    = 3'd0;
        tx_div_d    = clamp_div(baud_q, MIN_DIV);
        tx_tmr_load = 1'b1;
        tx_tmr_val  = clamp_div(baud_q, MIN_DIV);
      end
      TX_START: if (tx_expire) begin
        tx_state_d  = TX_DATA;
        tx_d        = tx_shift_q[0];
        tx_shift_d  = tx_shift_q >> 1;
        tx_tmr_load = 1'b1;
      end
      TX_DATA: if (tx_expire) begin
        tx_tmr_load = 1'b1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_expire) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (wr_data && (tx_state_q != TX_IDLE)) tx_drop_d = 1'b1;
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_bit_d     = rx_bit_q;
    rx_div_d     = rx_div_q;
    rx_tmr_load  = 1'b0;
    rx_tmr_val   = rx_div_q;
    rx_byte_ok   = 1'b0;
    rx_frame_bad = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s_q) begin
        rx_state_d  = RX_START;
        rx_bit_d    = 3'd0;
        rx_div_d    = clamp_div(baud_q, MIN_DIV);
        rx_tmr_load = 1'b1;
        rx_tmr_val  = clamp_div(baud_q, MIN_DIV) >> 1;
      end
      RX_START: if (rx_expire) begin
        rx_state_d  = rx_s_q ? RX_IDLE : RX_DATA;
        rx_tmr_load = !rx_s_q;
      end
      RX_DATA: if (rx_expire) begin
        rx_shift_d  = {rx_s_q, rx_shift_q[7:1]};
        rx_tmr_load = 1'b1;
        rx_bit_d    = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_expire) begin
        rx_byte_ok   = rx_s_q;
        rx_frame_bad = !rx_s_q;
        rx_state_d   = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A same-cycle CONTROL clear makes room for the completing byte, so it lands without overrun.
  assign rx_valid_eff = rx_valid_q && !clr_valid;

  always_comb begin
    rx_valid_d   = rx_valid_eff;
    rx_data_d    = rx_data_q;
    rx_overrun_d = rx_overrun_q && !clr_err;
    rx_ferr_d    = (rx_ferr_q && !clr_err) || rx_frame_bad;
    if (rx_byte_ok) begin
      if (!rx_valid_eff) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q       <= DEFAULT_DIV;
      tx_state_q   <= TX_IDLE;
      tx_q         <= 1'b1;
      tx_shift_q   <= 8'h00;
      tx_bit_q     <= 3'd0;
      tx_div_q     <= DEFAULT_DIV;
      tx_drop_q    <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_shift_q   <= 8'h00;
      rx_bit_q     <= 3'd0;
      rx_div_q     <= DEFAULT_DIV;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      baud_q       <= baud_d;
      tx_state_q   <= tx_state_d;
      tx_q         <= tx_d;
      tx_shift_q   <= tx_shift_d;
      tx_bit_q     <= tx_bit_d;
      tx_div_q     <= tx_div_d;
      tx_drop_q    <= tx_drop_d;
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_shift_q   <= rx_shift_d;
      rx_bit_q     <= rx_bit_d;
      rx_div_q     <= rx_div_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

  always_comb begin
    status                  = 16'h0000;
    status[ST_TX_BUSY]      = (tx_state_q != TX_IDLE);
    status[ST_RX_VALID]     = rx_valid_q;
    status[ST_RX_OVERRUN]   = rx_overrun_q;
    status[ST_RX_FRAME_ERR] = rx_ferr_q;
    status[ST_TX_DROP]      = tx_drop_q;
  end

  always_comb begin
    out = 16'h0000;
    if (cs) begin
      unique case (reg_sel)
        REG_DATA:   out = {8'h00, rx_data_q};
        REG_STATUS: out = status;
        REG_BAUD:   out = baud_q;
        default:    out = 16'h0000;
      endcase
    end
  end

  assign tx = tx_q;

endmodule
